// File: rtl/rail_fence_pkg.sv
// Shared definitions for the 2-rail Rail-Fence encryptor/decryptor cores and their benches.
// Reference mappings: y[2k] = x[k], y[2k+1] = x[k+HALF_W].
package rail_fence_pkg;

    localparam int unsigned DEFAULT_DATA_W = 256;
    localparam int unsigned DEFAULT_HALF_W = DEFAULT_DATA_W / 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } rf_state_t;

    function automatic logic [DEFAULT_DATA_W-1:0] rf_encode(input logic [DEFAULT_DATA_W-1:0] x);
        logic [DEFAULT_DATA_W-1:0] y;
        y = '0;
        for (int unsigned k = 0; k < DEFAULT_HALF_W; k++) begin
            y[2*k]     = x[k];
            y[2*k + 1] = x[k + DEFAULT_HALF_W];
        end
        return y;
    endfunction

    function automatic logic [DEFAULT_DATA_W-1:0] rf_decode(input logic [DEFAULT_DATA_W-1:0] y);
        logic [DEFAULT_DATA_W-1:0] x;
        x = '0;
        for (int unsigned k = 0; k < DEFAULT_HALF_W; k++) begin
            x[k]                  = y[2*k];
            x[k + DEFAULT_HALF_W] = y[2*k + 1];
        end
        return x;
    endfunction

endpackage

// File: rtl/rail_fence_encoder_core.sv
// Bit-serial 2-rail Rail-Fence encryptor: one (hi, lo) rail pair per CALC cycle,
// result published in one step with a single-cycle o_finished pulse.
module rail_fence_encoder_core
    import rail_fence_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_new,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_dec,
    output logic [DATA_W-1:0] o_enc,
    output logic              o_finished,
    output logic              o_busy
);

    localparam int unsigned HALF_W = DATA_W / 2;
    localparam int unsigned CNT_W  = $clog2(HALF_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HALF_W - 1);

    rf_state_t          state_r;
    rf_state_t          state_nxt;
    logic [CNT_W-1:0]   cnt_r;
    logic [DATA_W-1:0]  plain_r;
    logic [DATA_W-3:0]  shift_r;
    logic [DATA_W-1:0]  shift_nxt;
    logic [HALF_W-1:0]  lo_rail;
    logic [HALF_W-1:0]  hi_rail;
    logic [1:0]         pair;
    logic               accept;
    logic               last;

    assign lo_rail   = plain_r[HALF_W-1:0];
    assign hi_rail   = plain_r[DATA_W-1:HALF_W];
    assign pair      = {hi_rail[cnt_r], lo_rail[cnt_r]};
    // Pairs enter at the MSB end; the oldest pair has reached bits [1:0] once
    // HALF_W pairs are in, so the bottom two bits never need to be stored.
    assign shift_nxt = {pair, shift_r};
    assign o_busy    = (state_r == S_CALC);

    always_ff @(posedge i_clk or negedge i_rst_new) begin
        if (!i_rst_new) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        accept    = 1'b0;
        last      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (i_start) begin
                    accept    = 1'b1;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_r == LAST_CNT) begin
                    last      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_new) begin
        if (!i_rst_new) begin
            plain_r    <= '0;
            shift_r    <= '0;
            cnt_r      <= '0;
            o_enc      <= '0;
            o_finished <= 1'b0;
        end else begin
            o_finished <= last;
            if (accept) begin
                plain_r <= i_dec;
                shift_r <= '0;
                cnt_r   <= '0;
            end else if (state_r == S_CALC) begin
                shift_r <= shift_nxt[DATA_W-1:2];
                if (last) begin
                    cnt_r <= '0;
                    o_enc <= shift_nxt;
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rail_fence_encoder_core.sv
// Scoreboard bench for rail_fence_encoder_core: driver pushes expected blocks,
// monitor pops and checks on every o_finished pulse.
module tb_rail_fence_encoder_core;
    import rail_fence_pkg::*;

    localparam int unsigned W    = 256;
    localparam int unsigned HALF = W / 2;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        int unsigned  due;
    } exp_t;

    logic         i_clk = 1'b0;
    logic         i_rst_new = 1'b0;
    logic         i_start = 1'b0;
    logic [W-1:0] i_dec = '0;
    logic [W-1:0] o_enc;
    logic         o_finished;
    logic         o_busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    exp_t        q[$];

    rail_fence_encoder_core #(.DATA_W(W)) dut (
        .i_clk      (i_clk),
        .i_rst_new  (i_rst_new),
        .i_start    (i_start),
        .i_dec      (i_dec),
        .o_enc      (o_enc),
        .o_finished (o_finished),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Independent reference: walks output bit positions rather than pair index.
    function automatic logic [W-1:0] ref_enc(input logic [W-1:0] x);
        logic [W-1:0] y;
        for (int j = 0; j < W; j++) begin
            y[j] = x[(j >> 1) + ((j & 1) * HALF)];
        end
        return y;
    endfunction

    function automatic logic [W-1:0] rand_block();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) begin
            v[i*32 +: 32] = $urandom();
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_rst_new && o_finished) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_finished: got pulse at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", o_enc, e.y);
                chk("latency", W'(cyc), W'(e.due));
                chk("round_trip", rf_decode(o_enc), e.x);
            end
        end
    end

    task automatic start_job(input logic [W-1:0] x, input bit track);
        @(negedge i_clk);
        i_start = 1'b1;
        i_dec   = x;
        @(posedge i_clk);
        #1;
        if (track) q.push_back('{x: x, y: ref_enc(x), due: cyc + HALF});
        @(negedge i_clk);
        i_start = 1'b0;
        i_dec   = rand_block();
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results still pending, expected 0", q.size());
            q.delete();
        end
        @(negedge i_clk);
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] a_res;
        bit           seen;

        // 1: reset
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_enc", o_enc, '0);
        chk("reset_fin", W'(o_finished), '0);
        chk("reset_busy", W'(o_busy), '0);
        i_rst_new = 1'b1;
        repeat (2) @(negedge i_clk);

        // 2: single bits, hand-computed targets
        x = '0; x[0] = 1'b1;
        start_job(x, 1'b1);
        wait_idle();
        y = '0; y[0] = 1'b1;
        chk("bit0", o_enc, y);

        x = '0; x[128] = 1'b1;
        start_job(x, 1'b1);
        chk("busy_high", W'(o_busy), W'(1));
        wait_idle();
        y = '0; y[1] = 1'b1;
        chk("bit128", o_enc, y);

        x = '0; x[255] = 1'b1;
        start_job(x, 1'b1);
        wait_idle();
        y = '0; y[255] = 1'b1;
        chk("bit255", o_enc, y);
        chk("idle_busy", W'(o_busy), '0);

        // 3: rails
        x = {128'h0, {128{1'b1}}};
        start_job(x, 1'b1);
        wait_idle();
        chk("lo_rail", o_enc, {64{4'h5}});
        x = {{128{1'b1}}, 128'h0};
        start_job(x, 1'b1);
        wait_idle();
        chk("hi_rail", o_enc, {64{4'hA}});

        // 4: start while busy is ignored
        x = rand_block();
        start_job(x, 1'b1);
        repeat (48) @(negedge i_clk);
        i_start = 1'b1;
        i_dec   = ~x;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("busy_during_calc", W'(o_busy), W'(1));
        wait_idle();
        repeat (140) @(negedge i_clk);
        chk("busy_ignored", o_enc, ref_enc(x));

        // 5: back-to-back with i_start held high
        x = rand_block();
        a_res = ref_enc(x);
        @(negedge i_clk);
        i_start = 1'b1;
        i_dec   = x;
        @(posedge i_clk);
        #1;
        q.push_back('{x: x, y: a_res, due: cyc + HALF});
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge i_clk);
            i_dec = ~x;
            if (o_finished) seen = 1'b1;
        end
        chk("b2b_first_seen", W'(seen), W'(1));
        @(posedge i_clk);
        #1;
        q.push_back('{x: ~x, y: ref_enc(~x), due: cyc + HALF});
        @(negedge i_clk);
        i_start = 1'b0;
        chk("b2b_busy", W'(o_busy), W'(1));
        repeat (HALF - 2) @(negedge i_clk);
        chk("b2b_hold", o_enc, a_res);
        wait_idle();

        // 6: abort mid-encode
        y = o_enc;
        start_job(rand_block(), 1'b0);
        repeat (58) @(negedge i_clk);
        i_rst_new = 1'b0;
        #1;
        chk("abort_enc", o_enc, '0);
        chk("abort_fin", W'(o_finished), '0);
        chk("abort_busy", W'(o_busy), '0);
        repeat (2) @(negedge i_clk);
        i_rst_new = 1'b1;
        repeat (200) @(negedge i_clk);
        chk("abort_no_result", o_enc, '0);

        // random blocks through the DUT
        for (int i = 0; i < 20; i++) begin
            start_job(rand_block(), 1'b1);
            wait_idle();
        end

        // package reference mapping against the bench model
        for (int i = 0; i < 1000; i++) begin
            x = rand_block();
            chk("pkg_encode", rf_encode(x), ref_enc(x));
            chk("pkg_decode", rf_decode(ref_enc(x)), x);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
